save_chunk_port: RTL and testbench

SAVE_CHUNK_PORT -- requirements
Module: save_chunk_port

---
 rtl/save_chunk_port.sv | 153 +++++++++++++++
 tb/tb_save_chunk_port.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/save_chunk_port.sv
// Chunk-addressed save/restore port: answers header queries and moves single
// elements between a shared initiator bus and a local RAM with a four-phase ack.
module save_chunk_port #(
  parameter int CHUNK_ID  = 0,
  parameter int WIDTH     = 1,
  parameter int LENGTH    = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 query_req,
  input  logic [7:0]           chunk_select,
  input  logic [31:0]          chunk_address,
  input  logic                 read_req,
  input  logic                 write_req,
  input  logic [63:0]          write_data,
  output logic [63:0]          read_data,
  output logic                 data_ack,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_we,
  output logic [63:0]          mem_wdata,
  input  logic [63:0]          mem_rdata,
  output logic                 hdr_mismatch
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    ACK_HOLD
  } state_t;

  localparam logic [7:0]  SEL_ID     = 8'(CHUNK_ID);
  localparam logic [1:0]  WIDTH_CODE = 2'(WIDTH);
  localparam logic [31:0] LENGTH_W   = 32'(LENGTH);
  localparam logic [63:0] HEADER     = {30'b0, WIDTH_CODE, LENGTH_W};
  localparam logic [63:0] ELEM_MASK  = (WIDTH_CODE == 2'd0) ? 64'h0000_0000_0000_00FF :
                                       (WIDTH_CODE == 2'd1) ? 64'h0000_0000_0000_FFFF :
                                       (WIDTH_CODE == 2'd2) ? 64'h0000_0000_FFFF_FFFF :
                                                              64'hFFFF_FFFF_FFFF_FFFF;

  state_t                 state_reg, state_next;
  logic [63:0]            rdata_reg, rdata_next;
  logic                   ack_reg, ack_next;
  logic [ADDR_BITS-1:0]   addr_reg, addr_next;
  logic                   rd_reg, rd_next;
  logic                   we_reg, we_next;
  logic [63:0]            wdata_reg, wdata_next;
  logic                   mis_reg, mis_next;
  logic                   range_reg, range_next;

  logic selected;
  logic addr_ok;
  logic hdr_ok;

  assign selected = (chunk_select == SEL_ID);
  assign addr_ok  = (chunk_address < LENGTH_W);
  assign hdr_ok   = (write_data[31:0] == LENGTH_W) && (write_data[33:32] == WIDTH_CODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
      ack_reg   <= 1'b0;
      addr_reg  <= '0;
      rd_reg    <= 1'b0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      mis_reg   <= 1'b0;
      range_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
      ack_reg   <= ack_next;
      addr_reg  <= addr_next;
      rd_reg    <= rd_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      mis_reg   <= mis_next;
      range_reg <= range_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    ack_next   = ack_reg;
    addr_next  = addr_reg;
    rd_next    = 1'b0;
    we_next    = 1'b0;
    wdata_next = wdata_reg;
    mis_next   = mis_reg;
    range_next = range_reg;
    case (state_reg)
      IDLE: begin
        if (selected) begin
          // Write wins over read, so a combined request with query is a scatter header.
          if (query_req && write_req) begin
            if (hdr_ok) begin
              ack_next   = 1'b1;
              state_next = ACK_HOLD;
            end else begin
              mis_next = 1'b1;
            end
          end else if (query_req && read_req) begin
            rdata_next = HEADER;
            ack_next   = 1'b1;
            state_next = ACK_HOLD;
          end else if (write_req) begin
            range_next = addr_ok;
            addr_next  = chunk_address[ADDR_BITS-1:0];
            we_next    = addr_ok;
            wdata_next = write_data & ELEM_MASK;
            state_next = WR_ISSUE;
          end else if (read_req) begin
            range_next = addr_ok;
            addr_next  = chunk_address[ADDR_BITS-1:0];
            rd_next    = addr_ok;
            state_next = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_next = RD_CAPTURE;
      RD_CAPTURE: begin
        rdata_next = range_reg ? (mem_rdata & ELEM_MASK) : 64'd0;
        ack_next   = 1'b1;
        state_next = ACK_HOLD;
      end
      WR_ISSUE: begin
        ack_next   = 1'b1;
        state_next = ACK_HOLD;
      end
      ACK_HOLD: begin
        if (!read_req && !write_req) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign read_data    = rdata_reg;
  assign data_ack     = ack_reg;
  assign mem_addr     = addr_reg;
  assign mem_rd       = rd_reg;
  assign mem_we       = we_reg;
  assign mem_wdata    = wdata_reg;
  assign hdr_mismatch = mis_reg;

endmodule

// File: tb/tb_save_chunk_port.sv
// Two ports (chunk 2 / 16-bit, chunk 4 / 8-bit) on one initiator bus, each with
// its own RAM; a latency-based model predicts every output cycle by cycle.
module tb_save_chunk_port;
  localparam int NC  = 1024;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic reset, query_req, read_req, write_req;
  logic [7:0] chunk_select;
  logic [31:0] chunk_address;
  logic [63:0] write_data;
  logic [1:0][63:0] read_data, mem_wdata, mem_rdata;
  logic [1:0][7:0] mem_addr;
  logic [1:0] data_ack, mem_rd, mem_we, hdr_mismatch;

  int cyc = 0;
  int nvec = 0;
  int nfail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    save_chunk_port #(
      .CHUNK_ID(gi == 0 ? 2 : 4), .WIDTH(gi == 0 ? 1 : 0), .LENGTH(256), .ADDR_BITS(8)
    ) u_dut (
      .clk(clk), .reset(reset), .query_req(query_req), .chunk_select(chunk_select),
      .chunk_address(chunk_address), .read_req(read_req), .write_req(write_req),
      .write_data(write_data), .read_data(read_data[gi]), .data_ack(data_ack[gi]),
      .mem_addr(mem_addr[gi]), .mem_rd(mem_rd[gi]), .mem_we(mem_we[gi]),
      .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]), .hdr_mismatch(hdr_mismatch[gi])
    );
  end

  function automatic int id_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int wid_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    if (w >= 3) return '1;
    return (64'd1 << (8 << w)) - 64'd1;
  endfunction

  function automatic logic [63:0] pat(input int i, input int a);
    if (i == 0 && a == 5) return 64'hDEAD_BEEF_1234_5678;
    return {16'hC0DE, 8'(i), 8'(a), (32'(a) * 32'h0101_0101) ^ 32'h8040_2010};
  endfunction

  // Local RAMs: registered read, reloaded with the known pattern while reset is high.
  logic [63:0] ram [2][256];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int a = 0; a < 256; a++) ram[i][a] <= pat(i, a);
      end else if (mem_we[i]) begin
        ram[i][mem_addr[i]] <= mem_wdata[i];
      end
      if (mem_rd[i]) mem_rdata[i] <= ram[i][mem_addr[i]];
    end
  end

  // Model state: expected outputs per instance per cycle.
  bit          exp_ack [2][NC];
  bit          exp_rd  [2][NC];
  bit          exp_we  [2][NC];
  bit          exp_dv  [2][NC];
  logic [7:0]  exp_addr[2][NC];
  logic [63:0] exp_wd  [2][NC];
  logic [63:0] exp_dat [2][NC];
  logic [63:0] shadow  [2][256];
  int mis_from[2] = '{BIG, BIG};
  int mis_to[2]   = '{BIG, BIG};

  task automatic chk(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d] cyc=%0d actual=%0h required=%0h", name, i, cyc, act, exp);
    end
  endtask

  bit [1:0] ack_prev = 2'b00;
  int rise[2], fall[2], rd_cyc[2], we_cyc[2];
  logic [63:0] rise_data[2], we_data[2];

  always @(negedge clk) begin
    if (chk_on && cyc < NC) begin
      for (int i = 0; i < 2; i++) begin
        chk(i, "data_ack", data_ack[i], exp_ack[i][cyc]);
        chk(i, "mem_rd", mem_rd[i], exp_rd[i][cyc]);
        chk(i, "mem_we", mem_we[i], exp_we[i][cyc]);
        chk(i, "hdr_mismatch", hdr_mismatch[i], cyc >= mis_from[i] && cyc < mis_to[i]);
        if (exp_rd[i][cyc] || exp_we[i][cyc]) chk(i, "mem_addr", mem_addr[i], exp_addr[i][cyc]);
        if (exp_we[i][cyc]) chk(i, "mem_wdata", mem_wdata[i], exp_wd[i][cyc]);
        if (exp_dv[i][cyc]) chk(i, "read_data", read_data[i], exp_dat[i][cyc]);
        if (data_ack[i] && !ack_prev[i]) begin
          rise[i] = cyc;
          rise_data[i] = read_data[i];
        end
        if (!data_ack[i] && ack_prev[i]) fall[i] = cyc;
        if (mem_rd[i]) rd_cyc[i] = cyc;
        if (mem_we[i]) begin
          we_cyc[i] = cyc;
          we_data[i] = mem_wdata[i];
        end
        ack_prev[i] = data_ack[i];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset becomes visible at cycle 'from': everything idle, read_data zero, flag cleared.
  task automatic model_reset(input int from);
    for (int i = 0; i < 2; i++) begin
      if (mis_from[i] < from) mis_to[i] = from;
      else mis_from[i] = BIG;
      for (int a = 0; a < 256; a++) shadow[i][a] = pat(i, a);
      for (int c = from; c < NC; c++) begin
        exp_ack[i][c] = 1'b0;
        exp_rd[i][c]  = 1'b0;
        exp_we[i][c]  = 1'b0;
        exp_dv[i][c]  = 1'b0;
      end
      exp_dv[i][from]  = 1'b1;
      exp_dat[i][from] = 64'd0;
    end
  endtask

  // Latencies: header 1, write 2, read 3; strobes one cycle after the request.
  task automatic model_xact(input int i, input int n, input bit q, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [63:0] wd, input int hold,
                            output int lat);
    logic [63:0] m;
    logic [63:0] val;
    bit has_data;
    m = mask_of(wid_of(i));
    val = 64'd0;
    has_data = 1'b0;
    lat = 0;
    if (q && wr) begin
      if (wd[31:0] == 32'd256 && wd[33:32] == 2'(wid_of(i))) lat = 1;
      else if (!(n + 1 >= mis_from[i] && n + 1 < mis_to[i])) begin
        mis_from[i] = n + 1;
        mis_to[i] = BIG;
      end
    end else if (q && rd) begin
      lat = 1;
      has_data = 1'b1;
      val = (64'(wid_of(i)) << 32) + 64'd256;
    end else if (wr) begin
      lat = 2;
      if (addr < 256) begin
        exp_we[i][n+1] = 1'b1;
        exp_addr[i][n+1] = addr[7:0];
        exp_wd[i][n+1] = wd & m;
        shadow[i][addr[7:0]] = wd & m;
      end
    end else if (rd) begin
      lat = 3;
      has_data = 1'b1;
      if (addr < 256) begin
        exp_rd[i][n+1] = 1'b1;
        exp_addr[i][n+1] = addr[7:0];
        val = shadow[i][addr[7:0]] & m;
      end
    end
    for (int c = n + lat; lat > 0 && c <= n + lat + hold; c++) begin
      exp_ack[i][c] = 1'b1;
      exp_dv[i][c]  = has_data;
      exp_dat[i][c] = val;
    end
  endtask

  task automatic xact(input logic [7:0] sel, input logic [7:0] sel_after, input bit q,
                      input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [63:0] wd, input int hold, output int n);
    int lat;
    int l;
    lat = 0;
    chunk_select = sel;
    query_req = q;
    read_req = rd;
    write_req = wr;
    chunk_address = addr;
    write_data = wd;
    n = cyc;
    for (int i = 0; i < 2; i++) begin
      if (int'(sel) == id_of(i)) begin
        model_xact(i, n, q, rd, wr, addr, wd, hold, l);
        lat = l;
      end
    end
    if (lat == 0) begin
      repeat (20) step();
    end else begin
      step();
      chunk_select = sel_after;
      while (cyc < n + lat + hold) step();
    end
    query_req = 1'b0;
    read_req = 1'b0;
    write_req = 1'b0;
    chunk_select = 8'hFF;
    step();
    step();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    query_req = 1'b0;
    read_req = 1'b0;
    write_req = 1'b0;
    chunk_select = 8'hFF;
    chunk_address = '0;
    write_data = '0;
    model_reset(1);
    chk_on = 1'b1;
    repeat (3) step();
    chk(0, "rst_mem_addr", mem_addr[0], 0);
    chk(1, "rst_mem_wdata", mem_wdata[1], 0);
    reset = 1'b0;
    step();

    // Gather header on chunk 2, ack held two extra cycles.
    xact(8'd2, 8'd2, 1, 1, 0, 0, 0, 2, n);
    chk(0, "hdr_data", rise_data[0], 64'h0000_0001_0000_0100);
    chk(0, "hdr_lat", rise[0] - n, 1);
    chk(0, "hdr_ack_len", fall[0] - rise[0], 3);
    xact(8'd4, 8'd4, 1, 1, 0, 0, 0, 0, n);
    chk(1, "hdr8_data", rise_data[1], 64'h0000_0000_0000_0100);

    // Element read, 16-bit, with chunk_select moving away after acceptance.
    xact(8'd2, 8'd3, 0, 1, 0, 32'd5, 0, 0, n);
    chk(0, "rd5_data", rise_data[0], 64'h5678);
    chk(0, "rd5_pulse", rd_cyc[0] - n, 1);
    chk(0, "rd5_lat", rise[0] - n, 3);
    xact(8'd2, 8'd2, 0, 1, 0, 32'd6, 0, 1, n);
    xact(8'd2, 8'd2, 0, 1, 0, 32'd300, 0, 0, n);
    chk(0, "rd_oor_data", rise_data[0], 0);

    // Element writes, 8-bit port.
    xact(8'd4, 8'd4, 0, 0, 1, 32'd3, 64'hFFAB, 0, n);
    chk(1, "wr3_wdata", we_data[1], 64'hAB);
    chk(1, "wr3_pulse", we_cyc[1] - n, 1);
    chk(1, "wr3_lat", rise[1] - n, 2);
    xact(8'd4, 8'd4, 0, 0, 1, 32'd300, 64'h55, 0, n);
    chk(1, "wr_oor_lat", rise[1] - n, 2);
    xact(8'd4, 8'd4, 0, 1, 0, 32'd3, 0, 0, n);
    chk(1, "rd3_back", rise_data[1], 64'hAB);

    // Simultaneous read+write is a write.
    xact(8'd2, 8'd2, 0, 1, 1, 32'd10, 64'h1111_2222_3333_4444, 0, n);
    chk(0, "both_wdata", we_data[0], 64'h4444);
    xact(8'd2, 8'd2, 0, 1, 0, 32'd10, 0, 0, n);
    chk(0, "rd10_back", rise_data[0], 64'h4444);

    // Scatter headers: wrong length, then matching; wrong width on the 8-bit port.
    xact(8'd2, 8'd2, 1, 0, 1, 0, 64'h0000_0001_0000_00FF, 0, n);
    chk(0, "mis_sticky", hdr_mismatch[0], 1);
    xact(8'd2, 8'd2, 1, 0, 1, 0, 64'h0000_0001_0000_0100, 0, n);
    chk(0, "hdr_wr_lat", rise[0] - n, 1);
    xact(8'd4, 8'd4, 1, 0, 1, 0, 64'h0000_0001_0000_0100, 0, n);

    // Deselected chunk.
    xact(8'd3, 8'd3, 0, 1, 0, 32'd5, 0, 0, n);

    // Reset while the read sits in RD_CAPTURE.
    chunk_select = 8'd2;
    read_req = 1'b1;
    chunk_address = 32'd7;
    n = cyc;
    exp_rd[0][n+1] = 1'b1;
    exp_addr[0][n+1] = 8'd7;
    step();
    step();
    reset = 1'b1;
    read_req = 1'b0;
    chunk_select = 8'hFF;
    model_reset(n + 3);
    step();
    chk(0, "rst_mid_ack", data_ack[0], 0);
    chk(0, "rst_mid_mis", hdr_mismatch[0], 0);
    reset = 1'b0;
    step();
    xact(8'd2, 8'd2, 0, 1, 0, 32'd5, 0, 0, n);
    chk(0, "rd5_after_rst", rise_data[0], 64'h5678);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
